// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, widths and limits for the BCD/binary conversion paths
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, FIN, DONE} state_t;
  localparam int NUM_DIGITS = 5;
  localparam int BCD_W = 4;
  localparam int ACC_W = 17;
  localparam logic [ACC_W-1:0] POS_LIMIT = 17'd32767;
  localparam logic [ACC_W-1:0] NEG_LIMIT = 17'd32768;
  function automatic logic has_bad(input logic [NUM_DIGITS*BCD_W-1:0] d);
    has_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) has_bad = has_bad | (d[i*BCD_W +: BCD_W] > 4'd9);
  endfunction
endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational acc*10 + digit using shifts and adds
module bcd_mac10
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [BCD_W-1:0] digit_i,
  output logic [ACC_W-1:0] acc_o
);
  assign acc_o = (acc_i << 3) + (acc_i << 1) + {{(ACC_W-BCD_W){1'b0}}, digit_i};
endmodule

// File: rtl/bcd_to_bin16.sv
// bcd_to_bin16: sign + 5 BCD digits to 16-bit two's complement, one digit per clock; BCD2BIN_SAT_EN saturates on overflow
module bcd_to_bin16
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        negative,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_W-1:0]            bin,
  output logic                        overflow,
  output logic                        bad_digit
);
  state_t state_q;
  logic [2:0] idx_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [NUM_DIGITS*BCD_W-1:0] dig_q;
  logic neg_q, bad_q, out_valid_q, ovf_q, bad_digit_q;
  logic [BIN_W-1:0] bin_q, bin_d, wrap_d;
  logic ovf_d;
  bcd_mac10 u_mac (
    .acc_i  (acc_q),
    .digit_i(dig_q[idx_q*BCD_W +: BCD_W]),
    .acc_o  (acc_d)
  );
  // range check and signed result, computed from the finished accumulator
  always_comb begin
    ovf_d  = neg_q ? (acc_q > NEG_LIMIT) : (acc_q > POS_LIMIT);
    wrap_d = neg_q ? (~acc_q[BIN_W-1:0] + 1'b1) : acc_q[BIN_W-1:0];
`ifdef BCD2BIN_SAT_EN
    bin_d  = bad_q ? '0 : ovf_d ? (neg_q ? 16'h8000 : 16'h7FFF) : wrap_d;
`else
    bin_d  = bad_q ? '0 : wrap_d;
`endif
  end
  // control FSM with accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      dig_q       <= '0;
      neg_q       <= 1'b0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          dig_q       <= digits;
          neg_q       <= negative;
          acc_q       <= '0;
          idx_q       <= 3'd4;
          bad_q       <= has_bad(digits);
          ovf_q       <= 1'b0;
          bad_digit_q <= 1'b0;
          state_q     <= CONV;
        end
        CONV: begin
          acc_q <= acc_d;
          idx_q <= idx_q - 3'd1;
          if (idx_q == 3'd0) state_q <= FIN;
        end
        FIN: begin
          bin_q       <= bin_d;
          ovf_q       <= !bad_q && ovf_d;
          bad_digit_q <= bad_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bin       = bin_q;
  assign overflow  = ovf_q;
  assign bad_digit = bad_digit_q;
endmodule

// File: tb/tb_bcd_to_bin16.sv
// tb_bcd_to_bin16: randomized self-checking bench for bcd_to_bin16 against an arithmetic model
module tb_bcd_to_bin16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, negative = 1'b0, out_ready = 1'b0;
  logic [19:0] digits = '0;
  logic in_ready, out_valid, overflow, bad_digit;
  logic [15:0] bin;
  int cmp = 0, bad = 0;
  bcd_to_bin16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .negative(negative),
    .digits(digits), .out_valid(out_valid), .out_ready(out_ready), .bin(bin),
    .overflow(overflow), .bad_digit(bad_digit)
  );
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model(input logic neg, input logic [19:0] d,
                                output logic [15:0] eb, output logic eo, output logic ed);
    int v, s;
    logic [19:0] dd;
    v = 0;
    ed = 1'b0;
    dd = d;
    for (int i = 4; i >= 0; i--) begin
      if (dd[i*4 +: 4] > 4'd9) ed = 1'b1;
      v = v * 10 + int'(dd[i*4 +: 4]);
    end
    s = neg ? -v : v;
    eo = !ed && (s > 32767 || s < -32768);
`ifdef BCD2BIN_SAT_EN
    eb = ed ? 16'h0 : eo ? (s < 0 ? 16'h8000 : 16'h7FFF) : 16'(s);
`else
    eb = ed ? 16'h0 : 16'(s);
`endif
  endfunction

  task automatic start(input logic neg, input logic [19:0] d);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    cmp++;
    if (!in_ready) begin
      bad++;
      $display("FAIL start_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    negative = neg;
    digits = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic neg, input logic [19:0] d, input int want_lat);
    logic [15:0] eb;
    logic eo, ed;
    int n;
    model(neg, d, eb, eo, ed);
    start(neg, d);
    wait_out(n);
    cmp++;
    if (!out_valid || (want_lat > 0 && n != want_lat)) begin
      bad++;
      $display("FAIL %s_latency: got %0d valid=%b want %0d", nm, n, out_valid, want_lat);
    end
    cmp++;
    if ({bin, overflow, bad_digit} !== {eb, eo, ed}) begin
      bad++;
      $display("FAIL %s: neg=%b d=%h got bin=%h ovf=%b bad=%b want bin=%h ovf=%b bad=%b",
               nm, neg, d, bin, overflow, bad_digit, eb, eo, ed);
    end
    ack();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    cmp++;
    if ({in_ready, out_valid, bin, overflow, bad_digit} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got rdy=%b ov=%b bin=%h ovf=%b bad=%b want 1 0 0000 0 0",
               in_ready, out_valid, bin, overflow, bad_digit);
    end
  endtask

  task automatic test_basic();
    run_check("basic_12345", 1'b0, 20'h12345, 6);
    cmp++;
    if (bin !== 16'h3039) begin
      bad++;
      $display("FAIL basic_const: got %h want 3039", bin);
    end
  endtask

  task automatic test_sign_edges();
    run_check("neg_32768", 1'b1, 20'h32768, 6);
    run_check("neg_zero", 1'b1, 20'h00000, 6);
    run_check("pos_32767", 1'b0, 20'h32767, 6);
  endtask

  task automatic test_overflow();
    run_check("pos_32768", 1'b0, 20'h32768, 6);
    run_check("neg_99999", 1'b1, 20'h99999, 6);
    run_check("pos_40000", 1'b0, 20'h40000, 6);
  endtask

  task automatic test_bad_digit();
    run_check("bad_12A45", 1'b0, 20'h12A45, 6);
    start(1'b0, 20'h00001);
    cmp++;
    if (bad_digit !== 1'b0) begin
      bad++;
      $display("FAIL bad_clear_on_accept: got %b want 0", bad_digit);
    end
    tick(10);
    ack();
    run_check("after_bad", 1'b0, 20'h00007, 6);
  endtask

  task automatic test_backpressure();
    logic [15:0] b0;
    int n;
    start(1'b1, 20'h01234);
    wait_out(n);
    b0 = bin;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp++;
      if ({out_valid, in_ready, bin, overflow, bad_digit} !== {1'b1, 1'b0, b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold_%0d: got ov=%b rdy=%b bin=%h want 1 0 %h", i, out_valid, in_ready, bin, b0);
      end
    end
    cmp++;
    if (b0 !== 16'hFB2E) begin
      bad++;
      $display("FAIL hold_value: got %h want fb2e", b0);
    end
    ack();
    cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL release: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_in_valid();
    logic [15:0] eb;
    logic eo, ed;
    int n;
    model(1'b0, 20'h00042, eb, eo, ed);
    start(1'b0, 20'h00042);
    in_valid = 1'b1;
    negative = 1'b1;
    digits = 20'h99999;
    wait_out(n);
    in_valid = 1'b0;
    cmp++;
    if ({bin, overflow, bad_digit} !== {eb, eo, ed}) begin
      bad++;
      $display("FAIL ignore_in_valid: got bin=%h ovf=%b bad=%b want %h %b %b", bin, overflow, bad_digit, eb, eo, ed);
    end
    ack();
  endtask

  task automatic test_abort();
    start(1'b0, 20'h54321);
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp++;
    if ({in_ready, out_valid, bin} !== {1'b1, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL abort: got rdy=%b ov=%b bin=%h want 1 0 0000", in_ready, out_valid, bin);
    end
    tick(10);
    cmp++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_stale: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [19:0] d;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 5; i++) d[i*4 +: 4] = 4'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : 9));
      run_check("rand", 1'($urandom), d, 6);
      tick($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_edges();
    test_overflow();
    test_bad_digit();
    test_backpressure();
    test_ignore_in_valid();
    run_check("pre_abort", 1'b0, 20'h00099, 6);
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
